// File: rtl/regfile_readback_checker.sv
// Register-file readback checker.
// It steps the datapath A-port read select over r0..r(NUM_REGS-1) and samples
// each value. Each value is compared against an internally generated Fibonacci
// sequence and held on the display bus for DWELL_CYCLES cycles. When the scan
// finishes, the block reports done, pass/fail, the first failing index and a
// saturating mismatch count.
module regfile_readback_checker #(
  parameter int          NUM_REGS     = 8,
  parameter int          DWELL_CYCLES = 50000000,
  parameter logic [15:0] FIRST_A      = 16'd1,
  parameter logic [15:0] FIRST_B      = 16'd1
) (
  input  logic        I_CLK,
  input  logic        I_NRESET,
  input  logic        I_START,
  input  logic [15:0] I_REG_DATA,
  output logic [3:0]  O_REG_SELECT,
  output logic [15:0] O_DISPLAY_VALUE,
  output logic        O_BUSY,
  output logic        O_DONE,
  output logic        O_PASS,
  output logic [3:0]  O_FAIL_INDEX,
  output logic [3:0]  O_ERROR_COUNT
);

  // The dwell counter only has to reach DWELL_CYCLES-1, so it is sized for that.
  localparam int             CNT_W    = (DWELL_CYCLES > 1) ? $clog2(DWELL_CYCLES) : 1;
  localparam logic [CNT_W-1:0] DW_LAST = (DWELL_CYCLES > 0) ? CNT_W'(DWELL_CYCLES - 1) : '0;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [3:0]     LAST_IDX = 4'(NUM_REGS - 1);
  localparam logic [3:0]     NO_FAIL  = 4'hF;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SELECT,
    S_COMPARE,
    S_DWELL,
    S_DONE
  } state_t;

  state_t           r_state;
  logic [3:0]       r_idx;
  logic [CNT_W-1:0] r_dwell_cnt;
  logic [15:0]      r_exp_prev;
  logic [15:0]      r_exp_curr;
  logic [3:0]       r_reg_select;
  logic [15:0]      r_display;
  logic             r_busy;
  logic             r_done;
  logic             r_pass;
  logic [3:0]       r_fail_index;
  logic [3:0]       r_error_count;

  logic [15:0]      w_expected;
  logic             w_mismatch;
  logic [3:0]       w_err_next;
  logic             w_advance;
  logic             w_last;

  // r0 is checked against FIRST_A. From r1 onwards the check uses the running
  // "current" term. This lets the pair stay put across the 0->1 step.
  assign w_expected = (r_idx == 4'd0) ? FIRST_A : r_exp_curr;
  assign w_mismatch = (I_REG_DATA != w_expected);
  assign w_err_next = ((r_state == S_COMPARE) && w_mismatch && (r_error_count != 4'hF))
                      ? r_error_count + 4'd1 : r_error_count;
  // Advance happens straight out of COMPARE when there is no dwell. Otherwise
  // it happens on the last dwell cycle.
  assign w_advance  = ((r_state == S_COMPARE) && (DWELL_CYCLES == 0)) ||
                      ((r_state == S_DWELL) && (r_dwell_cnt == DW_LAST));
  assign w_last     = (r_idx == LAST_IDX);

  // Scan sequencer: state, index, expected pair, dwell timer and all registered outputs.
  always_ff @(posedge I_CLK or negedge I_NRESET) begin
    if (!I_NRESET) begin
      r_state       <= S_IDLE;
      r_idx         <= 4'd0;
      r_dwell_cnt   <= '0;
      r_exp_prev    <= FIRST_A;
      r_exp_curr    <= FIRST_B;
      r_reg_select  <= 4'd0;
      r_display     <= 16'd0;
      r_busy        <= 1'b0;
      r_done        <= 1'b0;
      r_pass        <= 1'b0;
      r_fail_index  <= NO_FAIL;
      r_error_count <= 4'd0;
    end else begin
      case (r_state)
        S_IDLE, S_DONE: begin
          if (I_START) begin
            r_state       <= S_SELECT;
            r_idx         <= 4'd0;
            r_reg_select  <= 4'd0;
            r_dwell_cnt   <= '0;
            r_exp_prev    <= FIRST_A;
            r_exp_curr    <= FIRST_B;
            r_error_count <= 4'd0;
            r_fail_index  <= NO_FAIL;
            r_busy        <= 1'b1;
            r_done        <= 1'b0;
            r_pass        <= 1'b0;
          end
        end
        S_SELECT: begin
          // The select was presented on entry; this cycle lets the read data settle.
          r_state <= S_COMPARE;
        end
        S_COMPARE: begin
          r_display     <= I_REG_DATA;
          r_error_count <= w_err_next;
          if (w_mismatch && (r_fail_index == NO_FAIL)) begin
            r_fail_index <= r_idx;
          end
          r_state     <= S_DWELL;
          r_dwell_cnt <= '0;
        end
        S_DWELL: begin
          r_dwell_cnt <= r_dwell_cnt + CNT_ONE;
        end
        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
      endcase

      // The advance overrides the per-state next-state chosen above.
      if (w_advance) begin
        r_dwell_cnt <= '0;
        if (w_last) begin
          r_state <= S_DONE;
          r_busy  <= 1'b0;
          r_done  <= 1'b1;
          r_pass  <= (w_err_next == 4'd0);
        end else begin
          r_idx        <= r_idx + 4'd1;
          r_reg_select <= r_idx + 4'd1;
          r_state      <= S_SELECT;
        end
        if (r_idx != 4'd0) begin
          r_exp_prev <= r_exp_curr;
          r_exp_curr <= r_exp_prev + r_exp_curr;
        end
      end
    end
  end

  assign O_REG_SELECT    = r_reg_select;
  assign O_DISPLAY_VALUE = r_display;
  assign O_BUSY          = r_busy;
  assign O_DONE          = r_done;
  assign O_PASS          = r_pass;
  assign O_FAIL_INDEX    = r_fail_index;
  assign O_ERROR_COUNT   = r_error_count;

endmodule
